// File: rtl/ov5640_gray_stream.sv
// RGB565 camera stream to 8-bit luma with x/y and SOF/EOL/EOF tags.
// Frames are delimited by vsync; every frame is size-checked and completed frames are counted.
module ov5640_gray_stream #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int X_W   = 11,
    parameter int Y_W   = 10
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           frame_vsync,
    input  logic           pix_valid,
    input  logic [15:0]    pix_data,
    output logic           gray_valid,
    output logic [7:0]     gray_data,
    output logic [X_W-1:0] gray_x,
    output logic [Y_W-1:0] gray_y,
    output logic           gray_sof,
    output logic           gray_eol,
    output logic           gray_eof,
    output logic           frame_err,
    output logic [15:0]    frame_cnt
);

    typedef enum logic [1:0] {S_SYNC, S_WAIT, S_ACTIVE} state_t;

    state_t         r_state, w_state_nx;
    logic           r_vsync_d;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           r_done, r_ovf, r_frame_err;
    logic [15:0]    r_frame_cnt;

    logic           w_rise, w_fall, w_x_last, w_y_last;
    logic           w_accept, w_drop_ovf, w_clear, w_err;

    logic           r_s1_valid, r_s1_sof, r_s1_eol, r_s1_eof;
    logic [X_W-1:0] r_s1_x;
    logic [Y_W-1:0] r_s1_y;
    logic [15:0]    r_s1_pr, r_s1_pg, r_s1_pb;

    logic           r_g_valid, r_g_sof, r_g_eol, r_g_eof;
    logic [7:0]     r_g_data;
    logic [X_W-1:0] r_g_x;
    logic [Y_W-1:0] r_g_y;

    logic [7:0]     w_r8, w_g8, w_b8;
    logic [15:0]    w_sum;

    assign w_rise   = frame_vsync & ~r_vsync_d;
    assign w_fall   = ~frame_vsync & r_vsync_d;
    assign w_x_last = (r_x == X_W'(IMG_W - 1));
    assign w_y_last = (r_y == Y_W'(IMG_H - 1));

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= S_SYNC;
            r_vsync_d <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_vsync_d <= frame_vsync;
        end
    end

    // The size check at rise already accounts for a pixel arriving in the same cycle.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_drop_ovf = 1'b0;
        w_clear    = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            S_SYNC: if (w_rise) w_state_nx = S_WAIT;
            S_WAIT: begin
                if (w_fall) begin
                    w_clear    = 1'b1;
                    w_state_nx = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                w_accept   = pix_valid & ~r_done;
                w_drop_ovf = pix_valid & r_done;
                if (w_rise) begin
                    w_err      = ~(r_done | (w_accept & w_x_last & w_y_last))
                                 | r_ovf | w_drop_ovf;
                    w_state_nx = S_WAIT;
                end
            end
            default: w_state_nx = S_SYNC;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_frame_err <= w_err;
            if (w_clear) begin
                r_x    <= '0;
                r_y    <= '0;
                r_done <= 1'b0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_accept) begin
                    if (w_x_last) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                        if (w_y_last) begin
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                if (w_drop_ovf) r_ovf <= 1'b1;
            end
        end
    end

    assign w_r8  = {pix_data[15:11], pix_data[15:13]};
    assign w_g8  = {pix_data[10:5],  pix_data[10:9]};
    assign w_b8  = {pix_data[4:0],   pix_data[4:2]};
    assign w_sum = r_s1_pr + r_s1_pg + r_s1_pb;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_eof   <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_pr    <= '0;
            r_s1_pg    <= '0;
            r_s1_pb    <= '0;
            r_g_valid  <= 1'b0;
            r_g_sof    <= 1'b0;
            r_g_eol    <= 1'b0;
            r_g_eof    <= 1'b0;
            r_g_data   <= '0;
            r_g_x      <= '0;
            r_g_y      <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_sof   <= w_accept & (r_x == '0) & (r_y == '0);
            r_s1_eol   <= w_accept & w_x_last;
            r_s1_eof   <= w_accept & w_x_last & w_y_last;
            r_s1_x     <= r_x;
            r_s1_y     <= r_y;
            r_s1_pr    <= 16'(w_r8) * 16'd77;
            r_s1_pg    <= 16'(w_g8) * 16'd150;
            r_s1_pb    <= 16'(w_b8) * 16'd29;
            r_g_valid  <= r_s1_valid;
            r_g_sof    <= r_s1_sof;
            r_g_eol    <= r_s1_eol;
            r_g_eof    <= r_s1_eof;
            r_g_data   <= w_sum[15:8];
            r_g_x      <= r_s1_x;
            r_g_y      <= r_s1_y;
        end
    end

    assign gray_valid = r_g_valid;
    assign gray_data  = r_g_data;
    assign gray_x     = r_g_x;
    assign gray_y     = r_g_y;
    assign gray_sof   = r_g_sof;
    assign gray_eol   = r_g_eol;
    assign gray_eof   = r_g_eof;
    assign frame_err  = r_frame_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ov5640_gray_stream.sv
// Scoreboard bench for ov5640_gray_stream on a 4x2 frame: stimulus pushes expected
// luma/tags/arrival cycle, a negedge monitor pops and compares every gray_valid.
module tb_ov5640_gray_stream;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int XW = 2;
    localparam int YW = 1;

    typedef struct packed {
        logic [7:0]    d;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
        logic          eof;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b1, vs = 1'b0, pv = 1'b0;
    logic [15:0]   pd = '0;
    logic          gray_valid, gray_sof, gray_eol, gray_eof, frame_err;
    logic [7:0]    gray_data;
    logic [XW-1:0] gray_x;
    logic [YW-1:0] gray_y;
    logic [15:0]   frame_cnt;

    exp_t          q[$];
    int            n_vec = 0, n_miss = 0, err_cnt = 0;
    logic [31:0]   cyc = '0;
    int            tx = 0, ty = 0;
    logic          tdone = 1'b0, in_frame = 1'b0;

    ov5640_gray_stream #(.IMG_W(W), .IMG_H(H), .X_W(XW), .Y_W(YW)) dut (
        .sys_clk(clk), .sys_rst(rst), .frame_vsync(vs), .pix_valid(pv), .pix_data(pd),
        .gray_valid(gray_valid), .gray_data(gray_data), .gray_x(gray_x), .gray_y(gray_y),
        .gray_sof(gray_sof), .gray_eol(gray_eol), .gray_eof(gray_eof),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: every gray_valid must match the oldest expected pixel, on its cycle.
    initial forever begin
        exp_t e, g;
        @(negedge clk);
        if (frame_err) err_cnt++;
        if (gray_valid) begin
            n_vec++;
            g = '{d: gray_data, x: gray_x, y: gray_y, sof: gray_sof, eol: gray_eol,
                  eof: gray_eof, cyc: cyc};
            if (q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_pix: got d=%0d x=%0d y=%0d at cyc %0d, required none",
                         gray_data, gray_x, gray_y, cyc);
            end else begin
                e = q.pop_front();
                if (g !== e) begin
                    n_miss++;
                    $display("FAIL pix: got d=%0d x=%0d y=%0d sof=%b eol=%b eof=%b cyc=%0d, required d=%0d x=%0d y=%0d sof=%b eol=%b eof=%b cyc=%0d",
                             g.d, g.x, g.y, g.sof, g.eol, g.eof, g.cyc,
                             e.d, e.x, e.y, e.sof, e.eol, e.eof, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic send_pix(input logic [15:0] d, input logic [7:0] g);
        pd = d;
        pv = 1'b1;
        if (in_frame && !tdone) begin
            q.push_back('{d: g, x: XW'(tx), y: YW'(ty), sof: (tx == 0 && ty == 0),
                          eol: (tx == W - 1), eof: (tx == W - 1 && ty == H - 1), cyc: cyc + 2});
            if (tx == W - 1) begin
                tx = 0;
                if (ty == H - 1) tdone = 1'b1;
                else ty++;
            end else begin
                tx++;
            end
        end
        tick();
        pv = 1'b0;
    endtask

    task automatic vsync_rise();
        vs = 1'b1;
        tick();
        tick();
        in_frame = 1'b0;
    endtask

    task automatic vsync_fall();
        vs = 1'b0;
        tick();
        tick();
        tx = 0;
        ty = 0;
        tdone = 1'b0;
        in_frame = 1'b1;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        logic [15:0] colours [4];
        logic [7:0]  lumas   [4];
        colours = '{16'hF800, 16'h07E0, 16'h001F, 16'h0000};
        lumas   = '{8'd76, 8'd149, 8'd28, 8'd0};

        repeat (3) tick();
        check("reset_outputs",
              {gray_valid, gray_data, gray_x, gray_y, gray_sof, gray_eol, gray_eof, frame_err, frame_cnt}, '0);
        rst = 1'b0;
        tick();

        // pixels before any vsync are dropped
        repeat (5) send_pix(16'hFFFF, 8'd255);
        drain();
        check("cnt_before_sync", frame_cnt, 0);

        // full white frame
        vsync_rise();
        vsync_fall();
        repeat (8) send_pix(16'hFFFF, 8'd255);
        drain();
        check("cnt_frame1", frame_cnt, 1);
        vsync_rise();
        check("err_after_good1", err_cnt, 0);
        vsync_fall();

        // primary colours
        for (int i = 0; i < 8; i++) send_pix(colours[i % 4], lumas[i % 4]);
        drain();
        check("cnt_frame2", frame_cnt, 2);
        vsync_rise();
        check("err_after_good2", err_cnt, 0);
        vsync_fall();

        // short frame
        repeat (6) send_pix(16'hFFFF, 8'd255);
        drain();
        vsync_rise();
        check("err_short", err_cnt, 1);
        check("cnt_short", frame_cnt, 2);
        vsync_fall();

        // 8th pixel coincides with the vsync rise
        repeat (7) send_pix(16'hFFFF, 8'd255);
        vs = 1'b1;
        send_pix(16'h07E0, 8'd149);
        vsync_rise();
        drain();
        check("err_same_cycle", err_cnt, 1);
        check("cnt_same_cycle", frame_cnt, 3);
        vsync_fall();

        // long frame: two extra pixels dropped
        repeat (10) send_pix(16'hF800, 8'd76);
        drain();
        check("cnt_long", frame_cnt, 4);
        vsync_rise();
        check("err_long", err_cnt, 2);
        vsync_fall();

        // reset mid-frame while a pixel is on the output
        send_pix(16'hFFFF, 8'd255);
        send_pix(16'hFFFF, 8'd255);
        pd = 16'hFFFF;
        pv = 1'b1;
        tick();
        pv = 1'b0;
        tick();
        check("pre_reset_out", {gray_valid, gray_data, gray_x}, {1'b1, 8'd255, 2'd2});
        rst = 1'b1;
        #1;
        check("mid_reset_outputs",
              {gray_valid, gray_data, gray_x, gray_y, gray_sof, gray_eol, gray_eof, frame_err, frame_cnt}, '0);
        in_frame = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        repeat (3) send_pix(16'hFFFF, 8'd255);
        vs = 1'b1;
        tick();
        repeat (2) send_pix(16'hFFFF, 8'd255);
        drain();
        vsync_fall();
        repeat (8) send_pix(16'h001F, 8'd28);
        drain();
        check("cnt_after_reset", frame_cnt, 1);
        check("err_after_reset", err_cnt, 2);
        check("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
